// File: rtl/urng_pkg.sv
// Shared constants and types for the taus113 range sampler and its serial divider.
package urng_pkg;

  localparam int unsigned RND_W      = 32;
  localparam int unsigned PROD_W     = 64;
  localparam int unsigned DIV_CYCLES = 32;

  typedef enum logic {
    IDLE,
    DIV
  } cfg_state_t;

endpackage

// File: rtl/urng_mod_div.sv
// Serial restoring divider: one quotient bit per cycle, exposes only the remainder.
module urng_mod_div
  import urng_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [RND_W-1:0] dividend,
  input  logic [RND_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [RND_W-1:0] remainder
);

  localparam int unsigned CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RND_W-1:0] rem_q, rem_d;
  logic [RND_W-1:0] dvd_q, dvd_d;
  logic [RND_W-1:0] dsr_q, dsr_d;
  logic [RND_W:0]   trial;
  logic [RND_W-1:0] step_rem;

  always_comb begin
    trial    = {rem_q, dvd_q[RND_W-1]};
    step_rem = (trial >= {1'b0, dsr_q}) ? RND_W'(trial - {1'b0, dsr_q})
                                        : trial[RND_W-1:0];
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = '0;
        rem_d  = '0;
        dvd_d  = dividend;
        dsr_d  = divisor;
      end
    end else begin
      rem_d = step_rem;
      dvd_d = dvd_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  // remainder is the current step's result so it is valid during the done pulse
  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == LAST);
  assign remainder = step_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
    end
  end

endmodule

// File: rtl/urng_range_sampler.sv
// Unbiased uniform integers in [0, N) from a taus113 stream: Lemire multiply-shift with
// rejection, threshold from a serial divider, results buffered in a show-ahead FIFO.
module urng_range_sampler
  import urng_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      rnd_in,
  input  logic             rnd_valid,
  input  logic [31:0]      range_n,
  input  logic             cfg_load,
  output logic             cfg_busy,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] reject_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  cfg_state_t        state_q, state_d;
  logic [RND_W-1:0]  n_q, n_d;
  logic [RND_W-1:0]  thresh_q, thresh_d;
  logic              s1_valid_q, s1_valid_d;
  logic [PROD_W-1:0] s1_prod_q, s1_prod_d;
  logic [RND_W-1:0]  mem_q [FIFO_DEPTH];
  logic [RND_W-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [RND_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  rej_q, rej_d;

  logic             load_acc, take, s2_rej, s2_ok, push, pop;
  logic             div_start, div_busy, div_done;
  logic [RND_W-1:0] div_rem;

  // 2^32 - N in 32 bits is simply -N
  urng_mod_div u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (RND_W'(0) - range_n),
    .divisor   (range_n),
    .busy      (div_busy),
    .done      (div_done),
    .remainder (div_rem)
  );

  always_comb begin
    load_acc  = cfg_load && (state_q == IDLE);
    div_start = load_acc && (range_n > 32'd1);
    state_d   = state_q;
    n_d       = load_acc ? range_n : n_q;
    thresh_d  = thresh_q;
    case (state_q)
      IDLE: begin
        if (load_acc) thresh_d = '0;
        if (div_start) state_d = DIV;
      end
      DIV: begin
        if (div_done) thresh_d = div_rem;
        if (div_done || !div_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_busy = (state_q == DIV);

  // N = 0 places the raw sample in the high word; the zero low word can never be rejected
  always_comb begin
    take       = rnd_valid && !cfg_busy && !cfg_load;
    s1_valid_d = take;
    s1_prod_d  = s1_prod_q;
    if (take) begin
      s1_prod_d = (n_q == '0) ? {rnd_in, 32'h0}
                              : PROD_W'(rnd_in) * PROD_W'(n_q);
    end
    s2_rej = s1_valid_q && (s1_prod_q[RND_W-1:0] < thresh_q);
    s2_ok  = s1_valid_q && !s2_rej;
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : last_q;
  assign reject_cnt = rej_q;

  always_comb begin
    pop      = out_valid && out_ready;
    push     = s2_ok && ((count_q != DEPTH_C) || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    rej_d    = rej_q;
    if (load_acc) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rej_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = s1_prod_q[PROD_W-1:RND_W];
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        last_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
      if (s2_rej && (rej_q != '1)) rej_d = rej_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      thresh_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      rej_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      thresh_q   <= thresh_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      rej_q      <= rej_d;
    end
  end

endmodule

// File: tb/tb_urng_range_sampler.sv
// Directed bench for urng_range_sampler with hand-computed expected values.
module tb_urng_range_sampler;

  logic        clk;
  logic        rst_n;
  logic [31:0] rnd_in;
  logic        rnd_valid;
  logic [31:0] range_n;
  logic        cfg_load;
  logic        cfg_busy;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] reject_cnt;

  int checks = 0;
  int errors = 0;

  urng_range_sampler #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rnd_in     (rnd_in),
    .rnd_valid  (rnd_valid),
    .range_n    (range_n),
    .cfg_load   (cfg_load),
    .cfg_busy   (cfg_busy),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v);
    rnd_in    = v;
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] n);
    range_n  = n;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (cfg_busy && n < 200) begin
      n++;
      tick();
    end
    chk("idle_timeout", 32'(cfg_busy), 32'd0);
  endtask

  task automatic drain_one(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic passthrough_test(input string tag);
    out_ready = 1'b1;
    rnd_in    = 32'hDEADBEEF;
    rnd_valid = 1'b1;
    tick();
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    rnd_in = 32'h12345678;
    tick();
    rnd_valid = 1'b0;
    chk({tag, "_a_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_a_data"}, out_data, 32'hDEADBEEF);
    tick();
    chk({tag, "_b_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_b_data"}, out_data, 32'h12345678);
    tick();
    chk({tag, "_empty"}, 32'(out_valid), 32'd0);
    chk({tag, "_rej"}, 32'(reject_cnt), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] samp [6];
    rst_n     = 1'b0;
    rnd_in    = '0;
    rnd_valid = 1'b0;
    range_n   = '0;
    cfg_load  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_rej", 32'(reject_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: pass-through
    passthrough_test("t1");

    // 2: N = 6, threshold 4
    load(32'd6);
    chk("t2_busy_next", 32'(cfg_busy), 32'd1);
    wait_idle(n);
    chk("t2_busy_cycles", 32'(n), 32'd32);
    chk("t2_thresh", dut.thresh_q, 32'd4);
    send(32'h00000000);
    send(32'h80000000);
    send(32'h80000001);
    send(32'hFFFFFFFF);
    send(32'h00000001);
    tick();
    chk("t2_rej", 32'(reject_cnt), 32'd2);
    drain_one("t2_o0", 32'd3);
    drain_one("t2_o1", 32'd5);
    drain_one("t2_o2", 32'd0);
    chk("t2_empty", 32'(out_valid), 32'd0);
    chk("t2_hold", out_data, 32'd0);

    // 3: N = 1 and N = 2^31
    load(32'd1);
    chk("t3_n1_busy", 32'(cfg_busy), 32'd0);
    chk("t3_n1_rej_clr", 32'(reject_cnt), 32'd0);
    send(32'hCAFEBABE);
    chk("t3_n1_busy2", 32'(cfg_busy), 32'd0);
    tick();
    drain_one("t3_n1", 32'd0);
    load(32'h80000000);
    wait_idle(n);
    chk("t3_half_cycles", 32'(n), 32'd32);
    chk("t3_half_thresh", dut.thresh_q, 32'd0);
    send(32'hDEADBEEF);
    tick();
    drain_one("t3_half", 32'h6F56DF77);

    // 4: back-pressure with N = 0
    load(32'd0);
    chk("t4_busy", 32'(cfg_busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      samp[i] = 32'hA0000000 + 32'(i * 17);
      send(samp[i]);
    end
    tick();
    chk("t4_rej", 32'(reject_cnt), 32'd0);
    for (int i = 0; i < 4; i++) drain_one($sformatf("t4_o%0d", i), samp[i]);
    chk("t4_empty", 32'(out_valid), 32'd0);
    chk("t4_hold", out_data, samp[3]);

    // 5: cfg_load with 3 queued entries and one sample in S1
    send(32'h11111111);
    send(32'h22222222);
    send(32'h33333333);
    send(32'h44444444);
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    load(32'd7);
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    n = 0;
    while (cfg_busy && n < 200) begin
      rnd_valid = 1'b1;
      rnd_in    = 32'hFFFFFFFF - 32'(n);
      cfg_load  = (n == 5);
      range_n   = 32'd10;
      n++;
      tick();
    end
    rnd_valid = 1'b0;
    cfg_load  = 1'b0;
    chk("t5_busy_cycles", 32'(n), 32'd32);
    chk("t5_thresh", dut.thresh_q, 32'd4);
    tick();
    tick();
    chk("t5_no_out", 32'(out_valid), 32'd0);
    chk("t5_rej", 32'(reject_cnt), 32'd0);
    send(32'hFFFFFFFF);
    tick();
    drain_one("t5_n7", 32'd6);

    // 6: reset with a full FIFO, then reset mid-DIV
    load(32'd6);
    wait_idle(n);
    send(32'h00000000);
    for (int i = 0; i < 4; i++) send(32'hFFFFFFFF);
    tick();
    chk("t6_full_valid", 32'(out_valid), 32'd1);
    chk("t6_full_data", out_data, 32'd5);
    chk("t6_full_rej", 32'(reject_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_rej", 32'(reject_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    load(32'd6);
    repeat (10) tick();
    chk("t6_mid_busy", 32'(cfg_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_div_busy", 32'(cfg_busy), 32'd0);
    chk("t6_div_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_busy", 32'(cfg_busy), 32'd0);
    passthrough_test("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
